// File: rtl/adder_pkg.sv
// Shared types and helpers for the chunked add/subtract unit.
//   state_t    : control FSM states
//   flags_t    : NZCV-style condition flags
//   num_chunks : number of CHUNK-bit slices needed to cover WIDTH bits
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  typedef struct packed {
    logic carry;
    logic overflow;
    logic zero;
    logic negative;
  } flags_t;

  function automatic int unsigned num_chunks(input int unsigned width,
                                             input int unsigned chunk);
    return (width + chunk - 1) / chunk;
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// CHUNK-bit combinational ripple-carry adder.
//   a, b : operand slices
//   cin  : carry in
//   sum  : a + b + cin, low CHUNK bits
//   cout : carry out of bit CHUNK-1
module chunk_adder #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  always_comb begin
    logic c;
    c   = cin;
    sum = '0;
    for (int i = 0; i < CHUNK; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/chunked_addsub.sv
// Multi-cycle add/subtract unit: processes CHUNK bits per clock through a registered
// carry, with valid/ready handshakes on both sides and NZCV-style flags.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : operand handshake (src1, src2, sub)
//   out_valid / out_ready: result handshake (result, carry, overflow, zero, negative)
module chunked_addsub
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 11,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int unsigned NCH   = num_chunks(WIDTH, CHUNK);
  localparam int unsigned IDXW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned WBITS = $clog2(WIDTH);
  // Number of valid bits in the final (possibly partial) chunk.
  localparam int unsigned LASTW = WIDTH - (NCH - 1) * CHUNK;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCH - 1);

  state_t            state_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;        // already inverted for subtract
  logic              cy_q;
  logic [IDXW-1:0]   idx_q;
  logic [WIDTH-1:0]  result_q;
  flags_t            flags_q;

  logic [CHUNK-1:0]  a_chunk;
  logic [CHUNK-1:0]  b_chunk;
  logic [CHUNK-1:0]  sum;
  logic              cout;
  logic [WIDTH-1:0]  result_next;
  logic              final_carry;
  flags_t            flags_next;

  // Slice the current chunk; bits beyond WIDTH in a partial chunk read as zero.
  always_comb begin
    int base;
    base    = int'(idx_q) * int'(CHUNK);
    a_chunk = '0;
    b_chunk = '0;
    for (int i = 0; i < CHUNK; i++) begin
      if (base + i < int'(WIDTH)) begin
        a_chunk[i] = a_q[WBITS'(base + i)];
        b_chunk[i] = b_q[WBITS'(base + i)];
      end
    end
  end

  chunk_adder #(
    .CHUNK (CHUNK)
  ) u_chunk_adder (
    .a    (a_chunk),
    .b    (b_chunk),
    .cin  (cy_q),
    .sum  (sum),
    .cout (cout)
  );

  // Merge the chunk sum into the result and derive flags from the completed value.
  always_comb begin
    int base;
    base        = int'(idx_q) * int'(CHUNK);
    result_next = result_q;
    for (int i = 0; i < CHUNK; i++) begin
      if (base + i < int'(WIDTH)) begin
        result_next[WBITS'(base + i)] = sum[i];
      end
    end
    // Padding bits are zero, so the carry out of the MSB lands in sum[LASTW]
    // when the last chunk is partial.
    final_carry = cout;
    for (int i = 0; i < CHUNK; i++) begin
      if (i == int'(LASTW)) begin
        final_carry = sum[i];
      end
    end
    flags_next.carry    = final_carry;
    flags_next.overflow = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                          (result_next[WIDTH-1] != a_q[WIDTH-1]);
    flags_next.zero     = ~|result_next;
    flags_next.negative = result_next[WIDTH-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      cy_q     <= 1'b0;
      idx_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= src1;
            b_q     <= sub ? ~src2 : src2;
            cy_q    <= sub;
            idx_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          result_q <= result_next;
          cy_q     <= cout;
          idx_q    <= idx_q + IDXW'(1);
          if (idx_q == LAST_IDX) begin
            flags_q <= flags_next;
            idx_q   <= '0;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign carry     = flags_q.carry;
  assign overflow  = flags_q.overflow;
  assign zero      = flags_q.zero;
  assign negative  = flags_q.negative;

endmodule

// File: tb/tb_chunked_addsub.sv
// Bench for chunked_addsub: an 11/4 instance checked every cycle against an arithmetic
// model plus literal vectors, and an 8/3 instance for partial-chunk and mid-run reset.
module tb_chunked_addsub;

  localparam int WA = 11;
  localparam int CA = 4;
  localparam int NA = 3;
  localparam int WB = 8;
  localparam int CB = 3;
  localparam int NB = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_a, in_valid_a, in_ready_a, sub_a, out_valid_a, out_ready_a;
  logic [WA-1:0] src1_a, src2_a, result_a;
  logic          carry_a, overflow_a, zero_a, negative_a;

  logic          rst_b, in_valid_b, in_ready_b, sub_b, out_valid_b, out_ready_b;
  logic [WB-1:0] src1_b, src2_b, result_b;
  logic          carry_b, overflow_b, zero_b, negative_b;

  chunked_addsub #(.WIDTH(WA), .CHUNK(CA)) dut_a (
    .clk(clk), .rst(rst_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .src1(src1_a), .src2(src2_a), .sub(sub_a), .out_valid(out_valid_a),
    .out_ready(out_ready_a), .result(result_a), .carry(carry_a),
    .overflow(overflow_a), .zero(zero_a), .negative(negative_a)
  );

  chunked_addsub #(.WIDTH(WB), .CHUNK(CB)) dut_b (
    .clk(clk), .rst(rst_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .src1(src1_b), .src2(src2_b), .sub(sub_b), .out_valid(out_valid_b),
    .out_ready(out_ready_b), .result(result_b), .carry(carry_b),
    .overflow(overflow_b), .zero(zero_b), .negative(negative_b)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Arithmetic model: returns {C, V, Z, N, result} for WA-bit operands.
  function automatic logic [WA+3:0] model_a(input logic [WA-1:0] a, input logic [WA-1:0] b,
                                            input logic s);
    int ai, bi, r, sa, sb, sr;
    logic [WA-1:0] res;
    logic c, v;
    ai  = int'(a);
    bi  = int'(b);
    r   = s ? ai - bi : ai + bi;
    res = r[WA-1:0];
    c   = s ? (ai >= bi) : (r >= (1 << WA));
    sa  = a[WA-1] ? ai - (1 << WA) : ai;
    sb  = b[WA-1] ? bi - (1 << WA) : bi;
    sr  = s ? sa - sb : sa + sb;
    v   = (sr > (1 << (WA - 1)) - 1) || (sr < -(1 << (WA - 1)));
    return {c, v, res == '0, res[WA-1], res};
  endfunction

  // Model of instance A in terms of edge numbers: busy from acceptance until the
  // output handshake; output valid once NA edges have passed since acceptance.
  int            edge_n   = 0;
  int            acc_edge = 0;
  bit            busy     = 1'b0;
  logic [WA-1:0] m_res    = '0;
  logic          m_c = 1'b0, m_v = 1'b0, m_z = 1'b0, m_n = 1'b0;

  always @(posedge clk) begin
    edge_n <= edge_n + 1;
    if (rst_a) begin
      busy <= 1'b0;
    end else if (!busy) begin
      if (in_valid_a) begin
        busy     <= 1'b1;
        acc_edge <= edge_n;
        {m_c, m_v, m_z, m_n, m_res} <= model_a(src1_a, src2_a, sub_a);
      end
    end else if ((edge_n - acc_edge > NA) && out_ready_a) begin
      busy <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!rst_a) begin
      check("cmp_in_ready", 32'(in_ready_a), 32'(!busy));
      check("cmp_out_valid", 32'(out_valid_a), 32'(busy && (edge_n - acc_edge > NA)));
      if (busy && (edge_n - acc_edge > NA)) begin
        check("cmp_result", 32'(result_a), 32'(m_res));
        check("cmp_flags", 32'({carry_a, overflow_a, zero_a, negative_a}),
              32'({m_c, m_v, m_z, m_n}));
      end
    end
  end

  // Issue one op on A, check latency and literal results, optionally hold
  // backpressure for `hold` cycles with ignored in_valid pulses, then retire it.
  task automatic op_a(input logic [WA-1:0] a, input logic [WA-1:0] b, input logic s,
                      input logic [WA-1:0] exp_res, input logic [3:0] exp_cvzn,
                      input int hold);
    int lat;
    @(posedge clk); #2;
    src1_a = a; src2_a = b; sub_a = s; in_valid_a = 1'b1; out_ready_a = 1'b0;
    @(posedge clk); #2;
    in_valid_a = 1'b0; src2_a = ~b; sub_a = ~s;
    lat = 0;
    while (lat < 20) begin
      @(posedge clk); lat++; #1;
      if (out_valid_a) break;
    end
    check("lat_a", 32'(lat), 32'(NA));
    check("res_a", 32'(result_a), 32'(exp_res));
    check("cvzn_a", 32'({carry_a, overflow_a, zero_a, negative_a}), 32'(exp_cvzn));
    for (int i = 0; i < hold; i++) begin
      #1; in_valid_a = 1'b1; src1_a = 11'h123; src2_a = 11'h456; sub_a = i[0];
      @(posedge clk); #1;
      check("bp_valid", 32'(out_valid_a), 32'(1));
      check("bp_ready", 32'(in_ready_a), 32'(0));
      check("bp_result", 32'(result_a), 32'(exp_res));
      check("bp_flags", 32'({carry_a, overflow_a, zero_a, negative_a}), 32'(exp_cvzn));
    end
    #1; in_valid_a = 1'b0; out_ready_a = 1'b1;
    @(posedge clk); #1;
    check("ret_valid", 32'(out_valid_a), 32'(0));
    check("ret_ready", 32'(in_ready_a), 32'(1));
    out_ready_a = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    rst_a = 1'b1; in_valid_a = 1'b0; out_ready_a = 1'b0;
    src1_a = '0; src2_a = '0; sub_a = 1'b0;
    rst_b = 1'b1; in_valid_b = 1'b0; out_ready_b = 1'b0;
    src1_b = '0; src2_b = '0; sub_b = 1'b0;
    repeat (3) @(posedge clk);
    #2; rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready_a), 32'(1));
    check("rst_out_valid", 32'(out_valid_a), 32'(0));
    check("rst_result", 32'(result_a), 32'(0));
    check("rst_flags", 32'({carry_a, overflow_a, zero_a, negative_a}), 32'(0));

    // Instance A literal vectors ({C,V,Z,N}).
    op_a(11'b01101110101, 11'b10011100010, 1'b0, 11'b00001010111, 4'b1000, 0);
    op_a(11'b01101110101, 11'b10011100010, 1'b1, 11'b11010010011, 4'b0101, 0);
    op_a(11'b01111111111, 11'b00000000001, 1'b0, 11'b10000000000, 4'b0101, 0);
    op_a(11'b01101110101, 11'b01101110101, 1'b1, 11'b00000000000, 4'b1010, 5);
    op_a(11'h400, 11'h001, 1'b1, 11'h3FF, 4'b1100, 0);
    op_a(11'h7FF, 11'h7FF, 1'b0, 11'h7FE, 4'b1001, 2);

    // Instance B: partial last chunk, 0xFF + 0x01.
    @(posedge clk); #2;
    src1_b = 8'hFF; src2_b = 8'h01; sub_b = 1'b0; in_valid_b = 1'b1;
    @(posedge clk); #2;
    in_valid_b = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(posedge clk); lat++; #1;
      if (out_valid_b) break;
    end
    check("lat_b", 32'(lat), 32'(NB));
    check("res_b", 32'(result_b), 32'(8'h00));
    check("cvzn_b", 32'({carry_b, overflow_b, zero_b, negative_b}), 32'(4'b1010));
    #1; out_ready_b = 1'b1;
    @(posedge clk); #1;
    check("ret_ready_b", 32'(in_ready_b), 32'(1));
    out_ready_b = 1'b0;

    // Instance B: reset during the second RUN cycle discards the operation.
    @(posedge clk); #2;
    src1_b = 8'h7F; src2_b = 8'h01; in_valid_b = 1'b1;
    @(posedge clk); #2;
    in_valid_b = 1'b0;
    check("run_ready_b", 32'(in_ready_b), 32'(0));
    @(posedge clk); #2;
    rst_b = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_ready", 32'(in_ready_b), 32'(1));
    check("mid_rst_valid", 32'(out_valid_b), 32'(0));
    check("mid_rst_result", 32'(result_b), 32'(0));
    check("mid_rst_flags", 32'({carry_b, overflow_b, zero_b, negative_b}), 32'(0));
    #1; rst_b = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("no_valid_b", 32'(out_valid_b), 32'(0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
